// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
// Request bundle and arbiter state encoding.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_port_arbiter_req_buffer.sv
// Single-entry pending-request buffer.
// A fresh capture wins over a same-cycle clear.
module arb_req_buffer
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cap,
  input  logic             i_clr,
  input  logic [REQ_W-1:0] i_req,
  output logic             o_valid,
  output logic [REQ_W-1:0] o_req
);

  logic             r_valid;
  logic [REQ_W-1:0] r_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (i_cap) begin
      r_valid <= 1'b1;
      r_req   <= i_req;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_req   = r_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges imem/dmem ports onto one cache port.
// dmem-first grant with lock-aware imem starvation relief.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  input  logic        lock,
  output logic [31:0] cache_addr,
  output logic [3:0]  cache_rmask,
  output logic [3:0]  cache_wmask,
  output logic [31:0] cache_wdata,
  input  logic [31:0] cache_rdata,
  input  logic        cache_resp
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  mem_req_t         r_cache;

  mem_req_t w_i_in, w_d_in;
  mem_req_t w_i_buf, w_d_buf;
  mem_req_t w_i_req, w_d_req, w_sel_req;
  logic     w_i_new, w_d_new;
  logic     w_i_vld, w_d_vld;
  logic     w_i_pend, w_d_pend;
  logic     w_resp_i, w_resp_d;
  logic     w_sel_i, w_sel_d;
  logic     w_starved;

  assign w_i_in = '{addr: imem_addr, rmask: imem_rmask,
                    wmask: 4'h0, wdata: 32'h0};
  assign w_d_in = '{addr: dmem_addr, rmask: dmem_rmask,
                    wmask: dmem_wmask, wdata: dmem_wdata};

  assign w_i_new = |imem_rmask;
  assign w_d_new = |dmem_rmask | |dmem_wmask;

  assign w_resp_i = (r_state == BUSY_I) && cache_resp;
  assign w_resp_d = (r_state == BUSY_D) && cache_resp;

  arb_req_buffer u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .i_cap   (w_i_new),
    .i_clr   (w_resp_i),
    .i_req   (w_i_in),
    .o_valid (w_i_vld),
    .o_req   (w_i_buf)
  );

  arb_req_buffer u_dbuf (
    .clk     (clk),
    .rst     (rst),
    .i_cap   (w_d_new),
    .i_clr   (w_resp_d),
    .i_req   (w_d_in),
    .o_valid (w_d_vld),
    .o_req   (w_d_buf)
  );

  // Bypass the buffer so a request can issue the very next cycle.
  assign w_i_pend = w_i_new | (w_i_vld & ~w_resp_i);
  assign w_d_pend = w_d_new | (w_d_vld & ~w_resp_d);
  assign w_i_req  = w_i_new ? w_i_in : w_i_buf;
  assign w_d_req  = w_d_new ? w_d_in : w_d_buf;

  assign w_starved = (r_cnt >= CNT_W'(STARVE_LIMIT)) && !lock;

  always_comb begin
    w_next    = r_state;
    w_sel_i   = 1'b0;
    w_sel_d   = 1'b0;
    w_sel_req = w_d_req;
    if (r_state == IDLE || w_resp_i || w_resp_d) begin
      if (w_i_pend && (!w_d_pend || w_starved)) begin
        w_sel_i   = 1'b1;
        w_sel_req = w_i_req;
      end else if (w_d_pend) begin
        w_sel_d = 1'b1;
      end
      unique case (1'b1)
        w_sel_i: w_next = BUSY_I;
        w_sel_d: w_next = BUSY_D;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cache <= '0;
    end else begin
      r_state       <= w_next;
      r_cache.rmask <= 4'h0;
      r_cache.wmask <= 4'h0;
      if (w_sel_i || w_sel_d) begin
        r_cache <= w_sel_req;
      end
      if (w_sel_i) begin
        r_cnt <= '0;
      end else if (w_sel_d && w_i_pend && !lock
                   && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cache_addr  = r_cache.addr;
  assign cache_rmask = r_cache.rmask;
  assign cache_wmask = r_cache.wmask;
  assign cache_wdata = r_cache.wdata;

  assign imem_resp  = w_resp_i;
  assign dmem_resp  = w_resp_d;
  assign imem_rdata = w_resp_i ? cache_rdata : 32'h0;
  assign dmem_rdata = w_resp_d ? cache_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Hand-computed grant order, latency and response routing.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        lock;
  logic [31:0] cache_addr;
  logic [3:0]  cache_rmask;
  logic [3:0]  cache_wmask;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata;
  logic        cache_resp;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .dmem_addr   (dmem_addr),
    .dmem_rmask  (dmem_rmask),
    .dmem_wmask  (dmem_wmask),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_resp   (dmem_resp),
    .lock        (lock),
    .cache_addr  (cache_addr),
    .cache_rmask (cache_rmask),
    .cache_wmask (cache_wmask),
    .cache_wdata (cache_wdata),
    .cache_rdata (cache_rdata),
    .cache_resp  (cache_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    cache_resp = 1'b0;
  endtask

  // At most one outstanding request per side.
  logic i_out = 1'b0;
  logic d_out = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      i_out <= 1'b0;
      d_out <= 1'b0;
    end else begin
      if (|imem_rmask && i_out && !imem_resp)
        $error("imem protocol violation");
      if ((|dmem_rmask || |dmem_wmask) && d_out && !dmem_resp)
        $error("dmem protocol violation");
      if (|imem_rmask) i_out <= 1'b1;
      else if (imem_resp) i_out <= 1'b0;
      if (|dmem_rmask || |dmem_wmask) d_out <= 1'b1;
      else if (dmem_resp) d_out <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    lock = 1'b0;
    imem_addr = '0;
    dmem_addr = '0;
    dmem_wdata = '0;
    cache_rdata = '0;
    idle_in();
    step();
    step();
    chk("rst_rmask", 32'(cache_rmask), 32'h0);
    chk("rst_wmask", 32'(cache_wmask), 32'h0);
    chk("rst_addr", cache_addr, 32'h0);
    chk("rst_wdata", cache_wdata, 32'h0);
    chk("rst_iresp", 32'(imem_resp), 32'h0);
    chk("rst_drdata", dmem_rdata, 32'h0);
    rst = 1'b1;
    step();

    // stray response in IDLE
    cache_resp = 1'b1;
    cache_rdata = 32'h1234_5678;
    #1;
    chk("idle_iresp", 32'(imem_resp), 32'h0);
    chk("idle_dresp", 32'(dmem_resp), 32'h0);
    step();
    idle_in();

    // lone imem read
    imem_addr = 32'h1eceb000;
    imem_rmask = 4'hF;
    step();
    idle_in();
    chk("t1_rmask", 32'(cache_rmask), 32'hF);
    chk("t1_addr", cache_addr, 32'h1eceb000);
    step();
    chk("t1_rmask0", 32'(cache_rmask), 32'h0);
    step();
    cache_resp = 1'b1;
    cache_rdata = 32'h0000_0013;
    #1;
    chk("t1_iresp", 32'(imem_resp), 32'h1);
    chk("t1_irdata", imem_rdata, 32'h0000_0013);
    chk("t1_dresp", 32'(dmem_resp), 32'h0);
    step();
    idle_in();
    #1;
    chk("t1_iresp0", 32'(imem_resp), 32'h0);

    // simultaneous: dmem store first, then imem with no bubble
    imem_addr = 32'h100;
    imem_rmask = 4'hF;
    dmem_addr = 32'h200;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'hDEADBEEF;
    step();
    idle_in();
    chk("t2_daddr", cache_addr, 32'h200);
    chk("t2_wmask", 32'(cache_wmask), 32'hF);
    chk("t2_wdata", cache_wdata, 32'hDEADBEEF);
    chk("t2_rmask", 32'(cache_rmask), 32'h0);
    step();
    cache_resp = 1'b1;
    #1;
    chk("t2_dresp", 32'(dmem_resp), 32'h1);
    chk("t2_iresp", 32'(imem_resp), 32'h0);
    step();
    idle_in();
    chk("t2_iaddr", cache_addr, 32'h100);
    chk("t2_irmask", 32'(cache_rmask), 32'hF);
    step();
    cache_resp = 1'b1;
    cache_rdata = 32'hCAFE_0001;
    #1;
    chk("t2_iresp2", 32'(imem_resp), 32'h1);
    chk("t2_irdata", imem_rdata, 32'hCAFE_0001);
    step();
    idle_in();

    // starvation: 4 dmem grants, then imem
    imem_addr = 32'h300;
    imem_rmask = 4'hF;
    dmem_addr = 32'h400;
    dmem_rmask = 4'hF;
    step();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_d%0d", k), cache_addr, 32'h400 + 32'(4 * k));
      step();
      cache_resp = 1'b1;
      dmem_addr = 32'h400 + 32'(4 * (k + 1));
      dmem_rmask = 4'hF;
      #1;
      chk($sformatf("st_dresp%0d", k), 32'(dmem_resp), 32'h1);
      step();
      idle_in();
    end
    chk("st_iaddr", cache_addr, 32'h300);
    chk("st_irmask", 32'(cache_rmask), 32'hF);
    chk("st_cnt0", 32'(dut.r_cnt), 32'h0);
    step();
    cache_resp = 1'b1;
    #1;
    chk("st_iresp", 32'(imem_resp), 32'h1);
    step();
    idle_in();
    chk("st_dlast", cache_addr, 32'h410);
    step();
    cache_resp = 1'b1;
    #1;
    chk("st_dresp_l", 32'(dmem_resp), 32'h1);
    step();
    idle_in();

    // lock: dmem wins for 6 grants, imem right after lock drops
    lock = 1'b1;
    imem_addr = 32'h500;
    imem_rmask = 4'hF;
    dmem_addr = 32'h600;
    dmem_rmask = 4'hF;
    step();
    idle_in();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("lk_d%0d", k), cache_addr, 32'h600 + 32'(4 * k));
      step();
      cache_resp = 1'b1;
      if (k < 5) begin
        dmem_addr = 32'h600 + 32'(4 * (k + 1));
        dmem_rmask = 4'hF;
      end else begin
        chk("lk_cnt", 32'(dut.r_cnt), 32'h0);
        lock = 1'b0;
      end
      step();
      idle_in();
    end
    chk("lk_iaddr", cache_addr, 32'h500);
    chk("lk_irmask", 32'(cache_rmask), 32'hF);
    step();
    cache_resp = 1'b1;
    #1;
    chk("lk_iresp", 32'(imem_resp), 32'h1);
    step();
    idle_in();

    // reset while BUSY_D drops the late response
    dmem_addr = 32'h700;
    dmem_rmask = 4'hF;
    step();
    idle_in();
    chk("rs_issue", cache_addr, 32'h700);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rs_addr0", cache_addr, 32'h0);
    chk("rs_rmask0", 32'(cache_rmask), 32'h0);
    step();
    cache_resp = 1'b1;
    cache_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rs_dresp", 32'(dmem_resp), 32'h0);
    chk("rs_drdata", dmem_rdata, 32'h0);
    step();
    idle_in();

    // refill on the imem resp cycle
    imem_addr = 32'h800;
    imem_rmask = 4'hF;
    step();
    idle_in();
    chk("rf_issue", cache_addr, 32'h800);
    step();
    cache_resp = 1'b1;
    cache_rdata = 32'h0000_0093;
    imem_addr = 32'h804;
    imem_rmask = 4'hF;
    #1;
    chk("rf_iresp", 32'(imem_resp), 32'h1);
    chk("rf_irdata", imem_rdata, 32'h0000_0093);
    step();
    idle_in();
    chk("rf_addr2", cache_addr, 32'h804);
    chk("rf_rmask2", 32'(cache_rmask), 32'hF);
    step();
    cache_resp = 1'b1;
    #1;
    chk("rf_iresp2", 32'(imem_resp), 32'h1);
    step();
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined core's split instruction and data memory ports.
- Merges imem and dmem requests onto a single cache request port, with one pending-request buffer per side.
- Grants dmem first, with starvation relief for imem, and routes each cache response back to the side that issued it.
- Honours the core's atomic lock by suspending starvation relief while lock is held.

Parameters:
- STARVE_LIMIT, 4: consecutive dmem grants allowed while imem is pending before imem is forced.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- imem_addr  in  32  instruction request address
- imem_rmask  in  4  instruction read mask; nonzero for one cycle = request
- imem_rdata  out  32  instruction read data
- imem_resp  out  1  one-cycle instruction response
- dmem_addr  in  32  data request address
- dmem_rmask  in  4  data read mask
- dmem_wmask  in  4  data write mask; request when rmask|wmask nonzero for one cycle
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  data read data
- dmem_resp  out  1  one-cycle data response
- lock  in  1  atomic sequence in progress at the core
- cache_addr  out  32  merged request address
- cache_rmask  out  4  merged read mask
- cache_wmask  out  4  merged write mask
- cache_wdata  out  32  merged write data
- cache_rdata  in  32  cache read data
- cache_resp  in  1  one-cycle cache response

Behaviour:
- Pending buffers:
  - Each side has one entry: valid, addr, rmask, wmask, wdata.
  - An entry is captured on the cycle its request mask is nonzero.
  - A requester issues at most one outstanding request per side; a new request before that side's resp is a protocol violation (bench asserts).
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If any entry is valid, select one, register it onto the cache_* outputs and move to BUSY_x.
  - The cache request is driven for exactly one cycle, the cycle after selection.
  - Fastest path: upstream request at cycle T, cache request at T+1.
- Selection rule:
  - dmem wins by default.
  - imem wins when dmem is not pending.
  - imem also wins when starve_cnt >= STARVE_LIMIT and lock=0.
  - While lock=1, dmem always wins and starve_cnt holds.
- starve_cnt:
  - Increments, saturating, on each dmem grant while imem is pending.
  - Clears on any imem grant.
- BUSY_x:
  - cache_* masks are 0 after the single issue cycle.
  - On cache_resp, drive x_resp=1 the same cycle with x_rdata = cache_rdata (combinational pass-through) and clear entry x.
  - In that same cycle, if another entry is valid, select it directly (no IDLE bubble) so the next cache request issues the following cycle. Otherwise return to IDLE.
- Response outside BUSY: cache_resp in IDLE is ignored, with no upstream resp. This covers stale responses after reset.
- Same-cycle events:
  - A request arriving on a side in the same cycle that side's resp is delivered is captured (the new entry overwrites the clearing one).
  - Requests arriving on both sides in the same cycle are both captured.
- Write requests: dmem_resp is still pulsed; dmem_rdata is don't-care.
- Reset (rst=0, synchronous):
  - All entries invalid, state IDLE, starve_cnt 0.
  - cache_addr/cache_wdata 0, cache masks 0.
  - imem_resp/dmem_resp 0; rdata outputs 0 when no resp.
  - Reset mid-transaction abandons the in-flight request; its late response is dropped.

Decomposition:
- Shared package (alongside the existing rv32i types): arb_state_t enum and a mem_req_t struct {addr, rmask, wmask, wdata}.
- One sub-module, arb_req_buffer, instantiated twice, one per side: a single-entry capture/clear buffer.

Test Plan:
- Lone imem read: imem request addr 0x1eceb000 at cycle 0 -> cache_rmask=0xF, addr 0x1eceb000 at cycle 1; cache_resp with rdata 0x00000013 at cycle 3 -> imem_resp=1, imem_rdata 0x00000013 at cycle 3; dmem_resp stays 0.
- Simultaneous requests: imem 0x100 and dmem store 0x200 (wmask 0xF, wdata 0xDEADBEEF) at cycle 0 -> dmem issued cycle 1; after its resp, imem issued the next cycle with no IDLE bubble.
- Starvation: imem pending with dmem re-requesting every resp -> exactly 4 dmem grants, then an imem grant; starve_cnt returns to 0.
- Lock: same as the starvation scenario with lock=1 -> dmem granted indefinitely; imem is granted within 2 cycles of lock falling, provided dmem is not re-requesting in that window.
- Reset mid-transaction: rst=0 while BUSY_D -> outputs zero next cycle; a cache_resp 2 cycles later produces no dmem_resp.
- Refill on resp cycle: new imem request in the same cycle as imem_resp -> captured and issued to the cache within 2 cycles.
